// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, types and fault check for the load/store unit
// Purpose: funct3 encodings, FSM state encoding, latched-request type, memory size
//          default and the request fault predicate.
// Ports:   none (package)
package lsu_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 5120;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_LOAD_RESP = 3'd2,
    ST_WRITE     = 3'd3,
    ST_FAULT     = 3'd4
  } lsu_state_t;

  // Only the byte offset of the address is kept; the aligned word address
  // lives in the Address register.
  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic req_faults(input logic        store,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input int unsigned mem_bytes);
    logic        bad;
    logic [32:0] end_addr;
    bad = 1'b0;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr[0];
      F3_W:        bad = (addr[1:0] != 2'b00);
      default:     bad = 1'b1;
    endcase
    if (store && funct3[2]) bad = 1'b1;
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    end_addr = {1'b0, addr[31:2], 2'b00} + 33'd4;
    if (end_addr > {1'b0, mem_bytes}) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and memory bus bundle of the load/store unit
// Purpose: groups the pipeline request/response handshake and the data-memory port.
// Ports:   req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata (request),
//          resp_valid/resp_data/resp_fault (response),
//          MemWrite/Address/Write_data/Read_data (memory port).
//          slave = the load/store unit, master = pipeline plus memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, Read_data,
    output req_ready, resp_valid, resp_data, resp_fault, MemWrite, Address, Write_data
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, Read_data,
    input  req_ready, resp_valid, resp_data, resp_fault, MemWrite, Address, Write_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - big-endian lane extraction and store merge
// Purpose: combinational lane logic for the load/store unit.
// Ports:   word (memory word), offset (byte offset), funct3, wdata (store data) in;
//          load_data (extended load result), store_word (merged word to write) out.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant byte.
  always_comb begin
    byte_lane = word[31:24];
    case (offset)
      2'd0: byte_lane = word[31:24];
      2'd1: byte_lane = word[23:16];
      2'd2: byte_lane = word[15:8];
      2'd3: byte_lane = word[7:0];
      default: byte_lane = word[31:24];
    endcase
    half_lane = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'd0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'd0, half_lane};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = wdata;
    case (funct3)
      F3_B: begin
        store_word = word;
        case (offset)
          2'd0: store_word[31:24] = wdata[7:0];
          2'd1: store_word[23:16] = wdata[7:0];
          2'd2: store_word[15:8]  = wdata[7:0];
          2'd3: store_word[7:0]   = wdata[7:0];
          default: store_word = word;
        endcase
      end
      F3_H: begin
        store_word = word;
        if (offset[1]) store_word[15:0]  = wdata[15:0];
        else           store_word[31:16] = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store sequencer for the single-port big-endian data memory
// Purpose: accepts one load/store, checks it, and runs read, read-modify-write or
//          word write against a memory with one-cycle registered read.
// Ports:   clk, rst_n (sync active-low); bus (load_store_unit_if.slave) carrying the
//          request/response handshake and MemWrite/Address/Write_data/Read_data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus
);

  localparam logic [2:0] IDLE      = ST_IDLE;
  localparam logic [2:0] READ      = ST_READ;
  localparam logic [2:0] LOAD_RESP = ST_LOAD_RESP;
  localparam logic [2:0] WRITE     = ST_WRITE;
  localparam logic [2:0] FAULT     = ST_FAULT;

  logic [2:0]  state_q;
  lsu_req_t    req_q;
  logic [31:0] addr_q;
  logic        accept;
  logic        fault_now;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign fault_now = req_faults(bus.req_store, bus.req_funct3, bus.req_addr, MEM_BYTES);

  // Address is a register so it keeps its last value in IDLE and FAULT;
  // a faulting request never moves it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q.store  <= bus.req_store;
            req_q.funct3 <= bus.req_funct3;
            req_q.offset <= bus.req_addr[1:0];
            req_q.wdata  <= bus.req_wdata;
            if (fault_now) begin
              state_q <= FAULT;
            end else begin
              addr_q  <= {bus.req_addr[31:2], 2'b00};
              // Only full-word stores skip the read of the old word.
              state_q <= (bus.req_store && bus.req_funct3 == F3_W) ? WRITE : READ;
            end
          end
        end
        READ:      state_q <= req_q.store ? WRITE : LOAD_RESP;
        LOAD_RESP: state_q <= IDLE;
        WRITE:     state_q <= IDLE;
        FAULT:     state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  lsu_lane_align u_lane_align (
    .word       (bus.Read_data),
    .offset     (req_q.offset),
    .funct3     (req_q.funct3),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == LOAD_RESP) || (state_q == WRITE) || (state_q == FAULT);
    bus.resp_fault = (state_q == FAULT);
    bus.resp_data  = (state_q == LOAD_RESP) ? load_data : 32'd0;
    bus.MemWrite   = (state_q == WRITE);
    bus.Address    = addr_q;
    // In WRITE after READ, Read_data holds the old word for the merge.
    bus.Write_data = (state_q == WRITE) ? store_word : 32'd0;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the byte-addressed, big-endian data memory. It accepts one load or store from the MEM stage and sequences the memory's single-port interface: one-cycle registered read and 4-byte word write. It converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into aligned word accesses. Loads are sign- or zero-extended. Sub-word stores use read-modify-write. Misaligned and out-of-range accesses are reported as faults without touching memory.

## Interface
- MEM_BYTES, 5120: addressable bytes. An access faults if aligned_addr + 4 > MEM_BYTES.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer on req_valid & req_ready at a rising edge
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  qualifies resp_valid; misaligned, illegal funct3 or out of range
- MemWrite  out  1  memory write enable
- Address  out  32  always word-aligned: {addr[31:2], 2'b00}
- Write_data  out  32  word written when MemWrite = 1
- Read_data  in  32  memory data, valid the cycle after Address is presented with MemWrite = 0

## Operation
- Byte lanes are big-endian: offset 0 = Read_data[31:24], offset 3 = [7:0]. The halfword at offset 0 = [31:16], at offset 2 = [15:0].
- Fault on any of:
  - H/HU with addr[0] = 1
  - W with addr[1:0] ≠ 0
  - funct3 ∈ {011, 110, 111}
  - a store with funct3[2] = 1
  - out of range
- FSM states: IDLE, READ, LOAD_RESP, WRITE, FAULT.
  - IDLE, on accept:
    - fault → FAULT
    - load → READ
    - SW → WRITE
    - SB/SH → READ
  - READ: Address = aligned address, MemWrite = 0. Next state is LOAD_RESP for loads, WRITE for SB/SH.
  - LOAD_RESP: extract the lane from Read_data and sign-extend (B/H) or zero-extend (BU/HU/W). resp_valid = 1 → IDLE.
  - WRITE: MemWrite = 1, Address = aligned address, resp_valid = 1, resp_data = 0 → IDLE.
    - SW: Write_data = latched req_wdata.
    - SB/SH: Write_data = Read_data with the target lane replaced by req_wdata[7:0] or [15:0]. Other lanes are unchanged.
  - FAULT: resp_valid = 1, resp_fault = 1, resp_data = 0, MemWrite = 0 → IDLE.
- The request (store, funct3, addr, wdata) is latched at accept. Input changes after accept have no effect.
- Exactly one outstanding request. req_ready = 0 in every non-IDLE state.
- MemWrite is high for exactly one cycle per non-faulting store and never for loads or faults.

## Timing
- Reset (rst_n = 0 at an edge): state = IDLE. Latched request registers = 0. Outputs next cycle:
  - req_ready = 1
  - resp_valid = 0, resp_fault = 0, resp_data = 0
  - MemWrite = 0, Address = 0, Write_data = 0
- Reset mid-operation (READ or WRITE) aborts the access. No write occurs in the cycle after the reset edge, and no response is issued.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - SB/SH: 2 cycles
  - SW: 1 cycle
  - fault: 1 cycle
- Next accept is possible the cycle after resp_valid. Maximum throughput is one request per 2 cycles (SW/fault) or 3 cycles (load/RMW).
- Outside READ/WRITE: MemWrite = 0, and Address holds its last value. Write_data = 0 outside WRITE.
- resp_* are driven combinationally from state plus latched and Read_data values. No response backpressure.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum lsu_state_t
  - MEM_BYTES default
- Sub-module lsu_lane_align (combinational) contains:
  - load extract/extend: inputs word, offset, funct3
  - store merge: inputs word, offset, funct3, wdata
- Top level holds the FSM and request latch.

## Test plan
- Preload bytes 0x10..0x13 = 11 22 33 84. Run LW 0x10, LB 0x13, LBU 0x13, LH 0x12, LHU 0x10 → resp_data 0x11223384, 0xFFFFFF84, 0x00000084, 0x00003384, 0x00001122; each 2 cycles after accept.
- SB 0x11 wdata 0x000000AB → one READ cycle, then one WRITE cycle with Address 0x10 and Write_data 0x11AB3384. Memory word then reads back 0x11AB3384.
- SH 0x12 wdata 0xDEADBEEF → Write_data 0x1122BEEF. SW 0x10 wdata 0xCAFEF00D → MemWrite the cycle after accept, resp_valid in the same cycle.
- LH 0x11, SW 0x12, funct3 011, and LW 0x1400 (out of range) → resp_fault = 1 one cycle after accept. MemWrite never high and memory unchanged.
- rst_n low in the READ cycle of SB 0x11 → no MemWrite pulse and no resp_valid. req_ready = 1 the cycle after reset. Memory is unchanged at 0x11223384.
- Hold req_valid high with back-to-back loads → req_ready low between accepts, one accept per 3 cycles. Each resp_data matches its own request.
